// File: rtl/input_memory_scheduler_pkg.sv
// Shared types and constants for the input vector path.
package input_memory_pkg;

  localparam int VECTOR_ADDR_W       = 9;
  localparam int ELEMENT_W           = 16;
  localparam int DEFAULT_PASS_LENGTH = 256;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_RUN,
    S_DRAIN,
    S_DONE
  } input_sched_state_t;

  typedef logic [VECTOR_ADDR_W-1:0] vaddr_t;
  typedef logic [ELEMENT_W-1:0]     elem_t;

  typedef struct packed {
    logic   en;
    logic   wr;
    vaddr_t addr;
    elem_t  data;
  } mem_req_t;

endpackage

// File: rtl/input_memory_scheduler_if.sv
// Host stream, manager control and vector memory port bundle.
interface input_memory_scheduler_if;
  import input_memory_pkg::*;

  logic   host_valid;
  logic   host_ready;
  elem_t  host_data;

  logic   mgr_en;
  logic   mgr_clear;
  vaddr_t mgr_memory_address;
  logic   mgr_memory_enable;
  logic   mgr_memory_write;
  elem_t  mgr_write_element;

  vaddr_t memory_address;
  logic   memory_enable;
  logic   memory_write;
  elem_t  memory_write_element;

  modport master (
    input  host_valid,
    input  host_data,
    input  mgr_memory_address,
    input  mgr_memory_enable,
    input  mgr_memory_write,
    input  mgr_write_element,
    output host_ready,
    output mgr_en,
    output mgr_clear,
    output memory_address,
    output memory_enable,
    output memory_write,
    output memory_write_element
  );

  modport slave (
    output host_valid,
    output host_data,
    output mgr_memory_address,
    output mgr_memory_enable,
    output mgr_memory_write,
    output mgr_write_element,
    input  host_ready,
    input  mgr_en,
    input  mgr_clear,
    input  memory_address,
    input  memory_enable,
    input  memory_write,
    input  memory_write_element
  );

endinterface

// File: rtl/input_memory_scheduler_image_load_address_generator.sv
// Row-major row/col counters for the host image load.
module image_load_address_generator
  import input_memory_pkg::*;
#(
  parameter int IMAGE_DIM = 12
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   clear_i,
  input  logic   inc_i,
  output logic   last_o,
  output vaddr_t addr_o
);

  localparam logic [3:0] LAST = 4'(IMAGE_DIM - 1);

  logic [3:0] row_q, row_d;
  logic [3:0] col_q, col_d;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear_i) begin
      row_d = '0;
      col_d = '0;
    end else if (inc_i) begin
      if (col_q == LAST) begin
        col_d = '0;
        row_d = row_q + 4'd1;
      end else begin
        col_d = col_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign last_o = (row_q == LAST) && (col_q == LAST);
  assign addr_o = {1'b0, row_q, col_q};

endmodule

// File: rtl/input_memory_scheduler.sv
// Load/run sequencer and vector memory port arbiter.
// Optional INPUT_SCHEDULER_PAUSE_EN adds a pause input that stalls RUN.
module input_memory_scheduler
  import input_memory_pkg::*;
#(
  parameter int IMAGE_DIM    = 12,
  parameter int PASS_LENGTH  = DEFAULT_PASS_LENGTH,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic clock,
  input  logic clear_n,
  input  logic start,
  input  logic start_reuse,
`ifdef INPUT_SCHEDULER_PAUSE_EN
  input  logic pause,
`endif
  output logic busy,
  output logic done,
  input_memory_scheduler_if.master bus
);

  localparam logic [8:0] RUN_LAST   = 9'(PASS_LENGTH - 1);
  localparam logic [8:0] DRAIN_LAST = 9'(DRAIN_CYCLES - 1);

  input_sched_state_t state_q, state_d;
  logic [8:0] run_q, run_d;
  mem_req_t   ld_q, ld_d;
  mem_req_t   mgr_req, mem;
  vaddr_t     gen_addr;
  logic       gen_last;
  logic       hold;
  logic       host_ready_w;
  logic       mgr_en_w;
  logic       flush_w;
  logic       xfer;
  logic       run_step;

`ifdef INPUT_SCHEDULER_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  assign xfer     = bus.host_valid && host_ready_w;
  assign run_step = (state_q == S_RUN) && !hold;

  image_load_address_generator #(
    .IMAGE_DIM (IMAGE_DIM)
  ) u_addr_gen (
    .clk_i   (clock),
    .rst_ni  (clear_n),
    .clear_i (state_q != S_LOAD),
    .inc_i   (xfer),
    .last_o  (gen_last),
    .addr_o  (gen_addr)
  );

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = start_reuse ? S_FLUSH : S_LOAD;
      S_LOAD:  if (xfer && gen_last) state_d = S_FLUSH;
      S_FLUSH: state_d = S_RUN;
      S_RUN:   if (run_step && run_q == RUN_LAST) state_d = S_DRAIN;
      S_DRAIN: if (run_q == DRAIN_LAST) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    host_ready_w = 1'b0;
    mgr_en_w     = 1'b0;
    flush_w      = 1'b0;
    done         = 1'b0;
    busy         = (state_q != S_IDLE);
    mem          = '0;
    unique case (state_q)
      S_LOAD: begin
        host_ready_w = 1'b1;
        mem          = ld_q;
      end
      S_FLUSH: begin
        flush_w = 1'b1;
        mem     = ld_q;
      end
      S_RUN: begin
        mgr_en_w = !hold;
        mem      = mgr_req;
      end
      S_DRAIN: mem = mgr_req;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Run counter doubles as the drain timer; it is idle-zero outside RUN/DRAIN.
  always_comb begin
    run_d = run_q;
    if (run_step) begin
      run_d = (run_q == RUN_LAST) ? '0 : run_q + 9'd1;
    end else if (state_q == S_DRAIN) begin
      run_d = run_q + 9'd1;
    end else if (state_q != S_RUN) begin
      run_d = '0;
    end
  end

  always_comb begin
    ld_d = '0;
    if (xfer) begin
      ld_d.en   = 1'b1;
      ld_d.wr   = 1'b1;
      ld_d.addr = gen_addr;
      ld_d.data = bus.host_data;
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      run_q <= '0;
      ld_q  <= '0;
    end else begin
      run_q <= run_d;
      ld_q  <= ld_d;
    end
  end

  assign mgr_req.en   = bus.mgr_memory_enable;
  assign mgr_req.wr   = bus.mgr_memory_write;
  assign mgr_req.addr = bus.mgr_memory_address;
  assign mgr_req.data = bus.mgr_write_element;

  assign bus.host_ready           = host_ready_w;
  assign bus.mgr_en               = mgr_en_w;
  assign bus.mgr_clear            = ~clear_n | flush_w;
  assign bus.memory_enable        = mem.en;
  assign bus.memory_write         = mem.wr;
  assign bus.memory_address       = mem.addr;
  assign bus.memory_write_element = mem.data;

endmodule

// File: tb/tb_input_memory_scheduler.sv
// Randomized bench for input_memory_scheduler against a timeline model.
module tb_input_memory_scheduler;
  import input_memory_pkg::*;

  localparam int DIM    = 12;
  localparam int NWORDS = DIM * DIM;
  localparam int PASS   = 256;

  logic clock = 1'b0;
  logic clear_n = 1'b0;
  logic start = 1'b0;
  logic start_reuse = 1'b0;
`ifdef INPUT_SCHEDULER_PAUSE_EN
  logic pause = 1'b0;
`endif
  logic busy;
  logic done;

  input_memory_scheduler_if ifc ();

  input_memory_scheduler #(
    .IMAGE_DIM    (DIM),
    .PASS_LENGTH  (PASS),
    .DRAIN_CYCLES (2)
  ) dut (
    .clock       (clock),
    .clear_n     (clear_n),
    .start       (start),
    .start_reuse (start_reuse),
`ifdef INPUT_SCHEDULER_PAUSE_EN
    .pause       (pause),
`endif
    .busy        (busy),
    .done        (done),
    .bus         (ifc)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [8:0] addr_of(input int n);
    return {1'b0, 4'(n / DIM), 4'(n % DIM)};
  endfunction

  function automatic logic [4:0] ctl_now();
    return {ifc.host_ready, ifc.mgr_clear, ifc.mgr_en, done, busy};
  endfunction

  function automatic logic [26:0] mem_now();
    return {ifc.memory_enable, ifc.memory_write,
            ifc.memory_address, ifc.memory_write_element};
  endfunction

  function automatic logic [26:0] mgr_now();
    return {ifc.mgr_memory_enable, ifc.mgr_memory_write,
            ifc.mgr_memory_address, ifc.mgr_write_element};
  endfunction

  task automatic drive_mgr();
    ifc.mgr_memory_enable  = ($urandom_range(0, 3) != 0);
    ifc.mgr_memory_write   = 1'($urandom_range(0, 1));
    ifc.mgr_memory_address = 9'($urandom);
    ifc.mgr_write_element  = 16'($urandom);
  endtask

  // Expected behaviour is a fixed timeline relative to the accepting edge:
  // load ends at klast, flush at f, 256 enabled cycles (+pause), 2 drain, done.
  task automatic run_job(input bit reuse, input int gap_pct,
                         input bit poke, input bit pause_on,
                         input string nm);
    bit vpat[1024];
    int klast, f, pz, dk, ntx, nwr, nen, ndone, prev_n;
    bit prev_xfer, inrun, paused;
    logic [4:0] ectl;
    logic [26:0] emem;
    klast = 0;
    ntx = 0;
    for (int k = 1; k < 1024; k++) begin
      vpat[k] = (k >= 600) || ($urandom_range(0, 99) >= gap_pct);
      if (!reuse && klast == 0 && vpat[k]) begin
        ntx++;
        if (ntx == NWORDS) klast = k;
      end
    end
    f = reuse ? 1 : klast + 1;
`ifdef INPUT_SCHEDULER_PAUSE_EN
    pz = pause_on ? 10 : 0;
`else
    pz = 0;
`endif
    dk = f + 259 + pz;
    ntx = 0;
    nwr = 0;
    nen = 0;
    ndone = 0;
    prev_xfer = 1'b0;
    prev_n = 0;
    start = 1'b1;
    start_reuse = reuse;
    ifc.host_valid = 1'b0;
    for (int k = 1; k <= dk + 3; k++) begin
      cyc();
      paused = pause_on && k >= f + 21 && k <= f + 30;
      start = poke && (k == 40 || k == f + 100);
      start_reuse = 1'($urandom_range(0, 1));
      ifc.host_valid = vpat[k];
      ifc.host_data = 16'(ntx);
      drive_mgr();
`ifdef INPUT_SCHEDULER_PAUSE_EN
      pause = paused;
`endif
      #1;
      inrun = k >= f + 1 && k <= f + 256 + pz;
      ectl = {!reuse && k <= klast, k == f, inrun && !paused,
              k == dk, k <= dk};
      chk({nm, "_ctl"}, 64'(ctl_now()), 64'(ectl));
      if (!reuse && k >= 2 && k <= f && prev_xfer)
        emem = {1'b1, 1'b1, addr_of(prev_n), 16'(prev_n)};
      else if (k > f && k < dk)
        emem = mgr_now();
      else
        emem = '0;
      chk({nm, "_mem"}, 64'(mem_now()), 64'(emem));
      if (k <= f && ifc.memory_enable && ifc.memory_write) nwr++;
      if (ifc.mgr_en) nen++;
      if (done) ndone++;
      prev_xfer = !reuse && vpat[k] && k <= klast;
      prev_n = ntx;
      if (prev_xfer) ntx++;
    end
    start = 1'b0;
`ifdef INPUT_SCHEDULER_PAUSE_EN
    pause = 1'b0;
`endif
    chk({nm, "_nwr"}, 64'(nwr), 64'(reuse ? 0 : NWORDS));
    chk({nm, "_nen"}, 64'(nen), 64'(PASS));
    chk({nm, "_ndone"}, 64'(ndone), 64'd1);
  endtask

  task automatic reset_mid_run();
    start = 1'b1;
    start_reuse = 1'b1;
    for (int k = 1; k <= 102; k++) begin
      cyc();
      start = 1'b0;
      drive_mgr();
      ifc.mgr_memory_enable = 1'b1;
      #1;
    end
    chk("rst_pre_en", 64'(ifc.mgr_en), 64'd1);
    #1;
    clear_n = 1'b0;
    #1;
    chk("rst_ctl", 64'(ctl_now()), 64'(5'b01000));
    chk("rst_mem", 64'(mem_now()), 64'd0);
    cyc();
    chk("rst_hold", 64'(ctl_now()), 64'(5'b01000));
    @(negedge clock);
    clear_n = 1'b1;
    cyc();
    #1;
    chk("rst_idle", 64'(ctl_now()), 64'(5'b00000));
    chk("rst_idle_mem", 64'(mem_now()), 64'd0);
  endtask

  initial begin
    ifc.host_valid = 1'b0;
    ifc.host_data = '0;
    drive_mgr();
    ifc.mgr_memory_enable = 1'b1;
    clear_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_ctl", 64'(ctl_now()), 64'(5'b01000));
    chk("reset_mem", 64'(mem_now()), 64'd0);
    @(negedge clock);
    clear_n = 1'b1;
    cyc();
    #1;
    chk("idle_ctl", 64'(ctl_now()), 64'(5'b00000));
    run_job(1'b1, 0, 1'b0, 1'b0, "reuse");
    run_job(1'b0, 30, 1'b0, 1'b0, "load");
    run_job(1'b0, 60, 1'b1, 1'b0, "poke");
    reset_mid_run();
    run_job(1'b1, 0, 1'b1, 1'b0, "after_rst");
`ifdef INPUT_SCHEDULER_PAUSE_EN
    run_job(1'b1, 0, 1'b0, 1'b1, "pause");
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
